serializer: RTL



---
 rtl/tx_pkg.sv | 34 +++
 rtl/serializer_if.sv | 33 +++
 rtl/serializer_prbs7.sv | 41 ++++
 rtl/serializer.sv | 122 ++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// +----------------------------------------------------------------------+
// | tx_pkg : shared TX-path constants, mode encoding and K28.5 helper     |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package tx_pkg;

  localparam int WORD_W = 10;

  localparam logic [1:0] TX_MODE_DATA = 2'b00;
  localparam logic [1:0] TX_MODE_PRBS = 2'b01;
  localparam logic [1:0] TX_MODE_CLK  = 2'b10;
  localparam logic [1:0] TX_MODE_K28  = 2'b11;

  typedef enum logic [1:0] {
    MODE_DATA = TX_MODE_DATA,
    MODE_PRBS = TX_MODE_PRBS,
    MODE_CLK  = TX_MODE_CLK,
    MODE_K28  = TX_MODE_K28
  } tx_mode_e;

  localparam logic [WORD_W-1:0] K28_5_RDN   = 10'b0011111010;
  localparam logic [WORD_W-1:0] K28_5_RDP   = 10'b1100000101;
  localparam logic [WORD_W-1:0] CLK_PATTERN = 10'b1010101010;

  // K28.5 code group for the running disparity currently in force.
  function automatic logic [WORD_W-1:0] k28_word(input logic rd_pos);
    return rd_pos ? K28_5_RDP : K28_5_RDN;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serializer_if.sv
// +----------------------------------------------------------------------+
// | serializer_if : encoder-side word bus and serial-side outputs        |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

interface serializer_if;

  logic [tx_pkg::WORD_W-1:0] TxParallel_10;
  logic [1:0]                TxMode;
  logic                      TxSerial;
  logic                      BitCLK_10;
  logic                      WordLoad;

  modport master (
    output TxParallel_10,
    output TxMode,
    input  TxSerial,
    input  BitCLK_10,
    input  WordLoad
  );

  modport slave (
    input  TxParallel_10,
    input  TxMode,
    output TxSerial,
    output BitCLK_10,
    output WordLoad
  );

endinterface

`default_nettype wire

// File: rtl/serializer_prbs7.sv
// +----------------------------------------------------------------------+
// | prbs7_gen : x^7+x^6+1 LFSR; steps only while enabled, else holds     |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module prbs7_gen #(
  parameter logic [6:0] SEED = 7'h7F
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic bit_o
);

  logic [6:0] lfsr_q;
  logic [6:0] lfsr_d;
  logic       w_fb;

  assign w_fb  = lfsr_q[6] ^ lfsr_q[5];
  assign bit_o = w_fb;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) begin
      // The all-zero state is a lockup for this polynomial; reseed out of it.
      lfsr_d = (lfsr_q == 7'd0) ? SEED : {lfsr_q[5:0], w_fb};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/serializer.sv
// +----------------------------------------------------------------------+
// | serializer : 10:1 MSB-first serializer, BitCLK/10 word clock, tests  |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module serializer
  import tx_pkg::*;
#(
  parameter int         WIDTH       = 10,
  parameter int         CAPTURE_CNT = 7,
  parameter logic [6:0] PRBS_SEED   = 7'h7F
) (
  input  logic           BitCLK,
  input  logic           Reset,
  serializer_if.slave    bus
);

  generate
    if (WIDTH != WORD_W || CAPTURE_CNT < 6 || CAPTURE_CNT > 9 || PRBS_SEED == 7'd0) begin : g_param_error
      $error("serializer: unsupported parameter set");
    end
  endgenerate

  localparam logic [3:0] CAP_CNT   = 4'(CAPTURE_CNT);
  localparam logic [3:0] LAST_CNT  = 4'd9;
  localparam logic [3:0] HIGH_LAST = 4'd4;

  logic [3:0]        cnt_q,    cnt_d;
  logic [WORD_W-1:0] hold_q,   hold_d;
  logic [WORD_W-1:0] shift_q,  shift_d;
  tx_mode_e          mode_q,   mode_d;
  tx_mode_e          act_q,    act_d;
  logic              k_rd_q,   k_rd_d;
  logic              tx_q,     tx_d;
  logic              bclk10_q, bclk10_d;
  logic              wl_q,     wl_d;

  logic              w_load;
  logic              w_cap;
  logic              w_prbs_en;
  logic              w_prbs_bit;

  assign w_load = (cnt_q == LAST_CNT);
  assign w_cap  = (cnt_q == CAP_CNT);

  // The captured mode becomes active only at the word boundary, so a mode
  // captured at cnt==7 never disturbs the word still being shifted out.
  assign act_d     = w_load ? mode_q : act_q;
  assign w_prbs_en = (act_d == MODE_PRBS);

  prbs7_gen #(
    .SEED  (PRBS_SEED)
  ) u_prbs7 (
    .clk   (BitCLK),
    .rst_n (Reset),
    .en_i  (w_prbs_en),
    .bit_o (w_prbs_bit)
  );

  always_comb begin
    cnt_d   = (cnt_q >= LAST_CNT) ? 4'd0 : cnt_q + 4'd1;
    hold_d  = hold_q;
    mode_d  = mode_q;
    k_rd_d  = k_rd_q;
    shift_d = shift_q << 1;

    if (w_cap) begin
      hold_d = bus.TxParallel_10;
      mode_d = tx_mode_e'(bus.TxMode);
    end

    if (w_load) begin
      unique case (mode_q)
        MODE_DATA: shift_d = hold_q;
        MODE_CLK:  shift_d = CLK_PATTERN;
        MODE_K28: begin
          shift_d = k28_word(k_rd_q);
          k_rd_d  = ~k_rd_q;
        end
        default:   shift_d = '0;
      endcase
    end

    // Driving TxSerial from the next shift value puts word bit 9 on the line
    // in the same cycle as WordLoad (cnt==0).
    tx_d     = w_prbs_en ? w_prbs_bit : shift_d[WORD_W-1];
    bclk10_d = (cnt_d <= HIGH_LAST);
    wl_d     = (cnt_d == 4'd0);
  end

  always_ff @(posedge BitCLK or negedge Reset) begin
    if (!Reset) begin
      cnt_q    <= 4'd0;
      hold_q   <= '0;
      shift_q  <= '0;
      mode_q   <= MODE_DATA;
      act_q    <= MODE_DATA;
      k_rd_q   <= 1'b0;
      tx_q     <= 1'b0;
      bclk10_q <= 1'b0;
      wl_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      shift_q  <= shift_d;
      mode_q   <= mode_d;
      act_q    <= act_d;
      k_rd_q   <= k_rd_d;
      tx_q     <= tx_d;
      bclk10_q <= bclk10_d;
      wl_q     <= wl_d;
    end
  end

  assign bus.TxSerial  = tx_q;
  assign bus.BitCLK_10 = bclk10_q;
  assign bus.WordLoad  = wl_q;

endmodule

`default_nettype wire
